register_bridge: RTL

Initiator for the memory-mapped register interface. Parses command packets from a UART byte receiver, issues single 32-bit reads and writes on the register bus (8-bit read and write addresses, 32-bit write data, write enable, registered read data), and returns response packets to a UART byte transmitter. It sits between the UART and the register block, so host software can read counters and buttons and drive LEDs over the serial link.

---
 rtl/register_bridge_if.sv | 25 ++
 rtl/register_bridge.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/register_bridge_if.sv
// UART byte stream and register-bus signals of the register bridge.
// The master modport is the bridge side. The slave modport is the
// environment side: the UART receiver/transmitter and the register block.
interface register_bridge_if;
  logic [7:0]  ipRxData;
  logic        ipRxValid;
  logic [7:0]  opTxData;
  logic        opTxValid;
  logic        ipTxReady;
  logic [7:0]  opReadAddress;
  logic [7:0]  opWriteAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic [31:0] ipRdData;

  modport master (
    input  ipRxData, ipRxValid, ipTxReady, ipRdData,
    output opTxData, opTxValid, opReadAddress, opWriteAddress, opWrData, opWrEnable
  );

  modport slave (
    output ipRxData, ipRxValid, ipTxReady, ipRdData,
    input  opTxData, opTxValid, opReadAddress, opWriteAddress, opWrData, opWrEnable
  );
endinterface

// File: rtl/register_bridge.sv
// Serial command bridge. It parses 0x55-framed read and write packets,
// runs single register-bus cycles, and streams the response packet back
// to the UART transmitter.
//
// state      | meaning
// IDLE       | waiting for the 0x55 sync byte
// CMD        | waiting for the command byte (0x00 read, 0x01 write)
// ADDR       | waiting for the address byte
// DATA       | collecting 4 write-data bytes, LSB first
// RD_ISSUE   | presenting the read address
// RD_WAIT    | waiting out the register block read latency
// RD_CAPTURE | latching read data into the response buffer
// WR_STROBE  | write strobe high with address and data
// TX         | sending the response bytes
module register_bridge #(
  parameter int TIMEOUT   = 50_000_000,
  parameter int READ_WAIT = 1
) (
  input  logic              ipClk,
  input  logic              ipReset,
  register_bridge_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_RD_ISSUE, S_RD_WAIT,
    S_RD_CAPTURE, S_WR_STROBE, S_TX
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_timer;
  logic [31:0] r_wait_cnt;
  logic        r_cmd_wr;
  logic [7:0]  r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_byte_cnt;
  logic [2:0]  r_tx_idx;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [7:0]  r_rd_addr;
  logic [7:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_wr_en;

  logic        w_timeout;
  logic        w_accept;
  logic        w_last_byte;
  logic [31:0] w_wr_word;

  // Response byte at a given index. The read data bytes follow the 3-byte header.
  function automatic logic [7:0] f_tx_byte(input logic [2:0] idx, input logic cmd_wr,
                                           input logic [7:0] addr, input logic [31:0] data);
    case (idx)
      3'd0:    return 8'h55;
      3'd1:    return {7'd0, cmd_wr};
      3'd2:    return addr;
      3'd3:    return data[7:0];
      3'd4:    return data[15:8];
      3'd5:    return data[23:16];
      default: return data[31:24];
    endcase
  endfunction

  // A byte that arrives on the timeout cycle wins, so the timeout is masked by ipRxValid.
  assign w_timeout   = (r_timer == 32'(TIMEOUT - 1)) && !bus.ipRxValid;
  assign w_accept    = r_tx_valid && bus.ipTxReady;
  assign w_last_byte = (r_tx_idx == (r_cmd_wr ? 3'd2 : 3'd6));
  assign w_wr_word   = {bus.ipRxData, r_data[31:8]};

  // State register.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode for packet parsing, bus sequencing and response transmission.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (bus.ipRxValid && bus.ipRxData == 8'h55) w_next = S_CMD;
      S_CMD: begin
        if (bus.ipRxValid)
          w_next = (bus.ipRxData == 8'h00 || bus.ipRxData == 8'h01) ? S_ADDR : S_IDLE;
        else if (w_timeout)
          w_next = S_IDLE;
      end
      S_ADDR: begin
        if (bus.ipRxValid) w_next = r_cmd_wr ? S_DATA : S_RD_ISSUE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DATA: begin
        if (bus.ipRxValid && r_byte_cnt == 2'd3) w_next = S_WR_STROBE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_RD_ISSUE:   w_next = (READ_WAIT == 0) ? S_RD_CAPTURE : S_RD_WAIT;
      S_RD_WAIT:    if (r_wait_cnt == 32'(READ_WAIT - 1)) w_next = S_RD_CAPTURE;
      S_RD_CAPTURE: w_next = S_TX;
      S_WR_STROBE:  w_next = S_TX;
      S_TX:         if (w_accept && w_last_byte) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Inter-byte timer: counts only while a packet is partly received.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset)
      r_timer <= '0;
    else if (bus.ipRxValid || !(r_state == S_CMD || r_state == S_ADDR || r_state == S_DATA))
      r_timer <= '0;
    else
      r_timer <= r_timer + 32'd1;
  end

  // Packet fields, bus outputs and the response stream.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      r_cmd_wr   <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_byte_cnt <= '0;
      r_wait_cnt <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: r_tx_idx <= '0;
        S_CMD:  if (bus.ipRxValid) r_cmd_wr <= bus.ipRxData[0];
        S_ADDR: if (bus.ipRxValid) begin
          r_addr     <= bus.ipRxData;
          r_byte_cnt <= '0;
        end
        S_DATA: if (bus.ipRxValid) begin
          r_data     <= w_wr_word;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_wr_word;
          end
        end
        S_RD_ISSUE: begin
          r_rd_addr  <= r_addr;
          r_wait_cnt <= '0;
        end
        S_RD_WAIT:    r_wait_cnt <= r_wait_cnt + 32'd1;
        S_RD_CAPTURE: r_data <= bus.ipRdData;
        S_TX: begin
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= f_tx_byte(r_tx_idx, r_cmd_wr, r_addr, r_data);
          end else if (w_accept) begin
            if (w_last_byte) begin
              r_tx_valid <= 1'b0;
              r_tx_idx   <= '0;
            end else begin
              r_tx_idx  <= r_tx_idx + 3'd1;
              r_tx_data <= f_tx_byte(r_tx_idx + 3'd1, r_cmd_wr, r_addr, r_data);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.opTxData       = r_tx_data;
  assign bus.opTxValid      = r_tx_valid;
  assign bus.opReadAddress  = r_rd_addr;
  assign bus.opWriteAddress = r_wr_addr;
  assign bus.opWrData       = r_wr_data;
  assign bus.opWrEnable     = r_wr_en;

endmodule
